vga_sync_decoder: RTL and testbench
===================================

Name: vga_sync_decoder

Overview:
- Receive end of the VGA timing interface that the Pong core drives: takes HSync/VSync as a monitor would see them and rebuilds pixel-clock-aligned x/y coordinates and data-enable.
- Reports lock and timing faults.
- Used as an in-fabric self-check of the video generator and by overlay logic that must track the displayed raster without tapping the generator's internal counters.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (px)
- H_SYNC, 96, hsync pulse width (px)
- H_BP, 48, horizontal back porch (px)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low)
- LOCK_LINES, 8, consecutive good lines required before vertical acquisition
- Derived: H_TOTAL = sum of H_* (800); V_TOTAL = sum of V_* (525).

Ports:
- px_clk  in  1  pixel clock; sole clock
- reset  in  1  synchronous, active-high
- hsync  in  1  incoming horizontal sync
- vsync  in  1  incoming vertical sync
- x  out  10  reconstructed column (h_cnt)
- y  out  10  reconstructed row (v_cnt)
- active  out  1  locked and inside visible area
- line_start  out  1  one-cycle pulse, x==0 on a visible line
- frame_start  out  1  one-cycle pulse, x==0 and y==0
- locked  out  1  timing acquired
- h_err  out  1  one-cycle pulse, horizontal timing violation
- v_err  out  1  one-cycle pulse, vertical timing violation

Behaviour:

Clocking and reset
- One clock (px_clk); reset is synchronous and active-high.
- Reset: all outputs 0; h_cnt, v_cnt, width counters, good_lines 0; FSM = SEARCH.

Input stage
- hsync/vsync pass through two flops, normalised by SYNC_POL to internal active-high hs/vs.
- A third flop provides edge detection.
- All outputs lag the pins by exactly 3 cycles.

Horizontal counter
- On hs rising edge: h_cnt <= H_ACTIVE+H_FP (656).
- Otherwise: h_cnt <= (h_cnt == H_TOTAL-1) ? 0 : h_cnt+1.
- Edge is good if pre-edge h_cnt == H_ACTIVE+H_FP-1; otherwise h_err pulses.
- hs high time is counted. On hs falling edge, width != H_SYNC pulses h_err. Width counter saturates at 1023.

Vertical counter
- v_cnt increments when h_cnt wraps H_TOTAL-1 -> 0, with wrap V_TOTAL-1 -> 0.
- On vs rising edge: v_cnt <= V_ACTIVE+V_FP (490), h_cnt unaffected.
- The edge is good if the value v_cnt would otherwise have taken this cycle equals 490; otherwise v_err pulses when state is V_CHK or LOCKED.
- vs width is counted in lines, i.e. h wraps while vs is high. Width != V_SYNC at the vs falling edge pulses v_err.

FSM
- SEARCH: first hs edge -> H_ACQ, good_lines = 0.
- H_ACQ:
  - Good hs edge with correct preceding width: good_lines++.
  - Any h_err: good_lines = 0.
  - good_lines == LOCK_LINES -> V_ACQ.
- V_ACQ: first vs edge loads v_cnt -> V_CHK. h_err -> SEARCH.
- V_CHK: next vs edge good -> LOCKED. Any h_err/v_err -> SEARCH.
- LOCKED: any h_err or v_err -> SEARCH; locked drops the following cycle.
- Any state except SEARCH: no hs edge for 2*H_TOTAL cycles -> SEARCH (loss of signal). Neither h_err nor v_err pulses for this.
- Errors are still pulsed in SEARCH/H_ACQ for horizontal checks; vertical checks only in V_CHK/LOCKED.

Outputs
- locked = (state == LOCKED), registered.
- x = h_cnt, y = v_cnt at all times. Consumers qualify them with active.
- active = locked && h_cnt < H_ACTIVE && v_cnt < V_ACTIVE.
- line_start = locked && h_cnt == 0 && v_cnt < V_ACTIVE.
- frame_start = locked && h_cnt == 0 && v_cnt == 0.

Simultaneous events and reset
- hs edge in the same cycle as the h wrap: the edge load wins.
- vs edge in the same cycle as the v wrap/increment: the vs load wins.
- Reset mid-frame returns to SEARCH; re-lock needs full acquisition.

Test Plan:
Use reduced parameters H 16/2/4/2 (H_TOTAL = 24), V 8/1/2/1 (V_TOTAL = 12), LOCK_LINES = 4, SYNC_POL = 0.

1. Clean stream from the matching generator starting mid-line -> locked rises after 4 good lines + V_ACQ vs edge + one full frame (12 lines) to the next vs edge. Thereafter:
   - active is high 16 px × 8 lines per frame.
   - frame_start fires every 288 cycles.
   - x/y equal generator counters delayed 3 cycles.
   - No h_err/v_err.
2. While locked, shorten one line to 23 px -> h_err pulses once at the early hs edge; locked low next cycle; re-lock after full acquisition.
3. While locked, hsync pulse width 5 instead of 4 -> h_err at the hs falling edge; FSM to SEARCH.
4. While locked, drop one line from a frame (11 lines) -> v_err at the early vs edge; locked drops.
5. Hold hsync inactive for 48 cycles while locked -> locked low on cycle 48; no error pulses; recovery on resumed stream.
6. Assert reset during V_CHK and mid-line in LOCKED -> all outputs 0 the next cycle; FSM in SEARCH.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - rebuilds raster x/y, data-enable and lock status from incoming hsync/vsync
module vga_sync_decoder #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_POL   = 0,
    parameter int LOCK_LINES = 8
) (
    input  logic       px_clk_i,
    input  logic       reset_i,
    input  logic       hsync_i,
    input  logic       vsync_i,
    output logic [9:0] x_o,
    output logic [9:0] y_o,
    output logic       active_o,
    output logic       line_start_o,
    output logic       frame_start_o,
    output logic       locked_o,
    output logic       h_err_o,
    output logic       v_err_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0]  H_LOAD   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  V_LOAD   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [11:0] LOS_LAST = 12'(2 * H_TOTAL - 1);
    localparam logic        POL      = (SYNC_POL != 0);

    typedef enum logic [2:0] {SEARCH, H_ACQ, V_ACQ, V_CHK, LOCKED} state_t;

    state_t      state_q, state_d;
    logic        hs_s1_q, hs_s2_q, hs_s3_q, vs_s1_q, vs_s2_q, vs_s3_q;
    logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, v_nat;
    logic [9:0]  hw_q, hw_d, vw_q, vw_d, vw_now;
    logic [11:0] los_q, los_d;
    logic [7:0]  gl_q, gl_d;
    logic        wok_q, wok_d, locked_q, h_err_q, h_err_d, v_err_q, v_err_d;
    logic        hs_rise, hs_fall, vs_rise, vs_fall, h_end, h_wrap, los_hit, v_chk;

    always_comb begin
        hs_rise = hs_s2_q & ~hs_s3_q;
        hs_fall = ~hs_s2_q & hs_s3_q;
        vs_rise = vs_s2_q & ~vs_s3_q;
        vs_fall = ~vs_s2_q & vs_s3_q;
        h_end   = (h_cnt_q == H_LAST);
        h_wrap  = h_end & ~hs_rise;

        h_cnt_d = hs_rise ? H_LOAD : (h_end ? 10'd0 : h_cnt_q + 10'd1);
        hw_d    = hs_rise ? 10'd1 : ((hs_s2_q && hw_q != 10'h3FF) ? hw_q + 10'd1 : hw_q);
        h_err_d = (hs_rise && h_cnt_q != H_LOAD - 10'd1) || (hs_fall && hw_q != 10'(H_SYNC));
        wok_d   = hs_fall ? (hw_q == 10'(H_SYNC)) : wok_q;

        v_nat   = h_wrap ? ((v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1) : v_cnt_q;
        v_cnt_d = vs_rise ? V_LOAD : v_nat;
        // The wrap that coincides with the vs falling edge still belongs to the pulse.
        vw_now  = (h_wrap && vs_s3_q && vw_q != 10'h3FF) ? vw_q + 10'd1 : vw_q;
        vw_d    = vs_rise ? 10'd0 : vw_now;
        v_chk   = (state_q == V_CHK) || (state_q == LOCKED);
        v_err_d = v_chk && ((vs_rise && v_nat != V_LOAD) || (vs_fall && vw_now != 10'(V_SYNC)));

        los_d   = hs_rise ? 12'd0 : ((los_q == 12'hFFF) ? los_q : los_q + 12'd1);
        los_hit = !hs_rise && (los_q == LOS_LAST);

        state_d = state_q;
        gl_d    = gl_q;
        if (state_q != SEARCH && los_hit) begin
            state_d = SEARCH;
        end else begin
            case (state_q)
                SEARCH: if (hs_rise) begin
                    state_d = H_ACQ;
                    gl_d    = 8'd0;
                end
                H_ACQ: begin
                    if (h_err_d) begin
                        gl_d = 8'd0;
                    end else if (hs_rise && wok_q) begin
                        gl_d = gl_q + 8'd1;
                        if (gl_q == 8'(LOCK_LINES - 1)) state_d = V_ACQ;
                    end
                end
                V_ACQ:   if (h_err_d) state_d = SEARCH; else if (vs_rise) state_d = V_CHK;
                V_CHK:   if (h_err_d || v_err_d) state_d = SEARCH; else if (vs_rise) state_d = LOCKED;
                LOCKED:  if (h_err_d || v_err_d) state_d = SEARCH;
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge px_clk_i) begin
        if (reset_i) begin
            state_q  <= SEARCH;
            hs_s1_q  <= 1'b0;
            hs_s2_q  <= 1'b0;
            hs_s3_q  <= 1'b0;
            vs_s1_q  <= 1'b0;
            vs_s2_q  <= 1'b0;
            vs_s3_q  <= 1'b0;
            h_cnt_q  <= 10'd0;
            v_cnt_q  <= 10'd0;
            hw_q     <= 10'd0;
            vw_q     <= 10'd0;
            los_q    <= 12'd0;
            gl_q     <= 8'd0;
            wok_q    <= 1'b0;
            locked_q <= 1'b0;
            h_err_q  <= 1'b0;
            v_err_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hs_s1_q  <= (hsync_i == POL);
            hs_s2_q  <= hs_s1_q;
            hs_s3_q  <= hs_s2_q;
            vs_s1_q  <= (vsync_i == POL);
            vs_s2_q  <= vs_s1_q;
            vs_s3_q  <= vs_s2_q;
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            hw_q     <= hw_d;
            vw_q     <= vw_d;
            los_q    <= los_d;
            gl_q     <= gl_d;
            wok_q    <= wok_d;
            locked_q <= (state_q == LOCKED);
            h_err_q  <= h_err_d;
            v_err_q  <= v_err_d;
        end
    end

    assign x_o           = h_cnt_q;
    assign y_o           = v_cnt_q;
    assign locked_o      = locked_q;
    assign h_err_o       = h_err_q;
    assign v_err_o       = v_err_q;
    assign active_o      = locked_q && (h_cnt_q < 10'(H_ACTIVE)) && (v_cnt_q < 10'(V_ACTIVE));
    assign line_start_o  = locked_q && (h_cnt_q == 10'd0) && (v_cnt_q < 10'(V_ACTIVE));
    assign frame_start_o = locked_q && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - randomized fault injection against a timestamp-based raster model
module tb_vga_sync_decoder;
    localparam int HA = 16, HF = 2, HS = 4, HB = 2;
    localparam int VA = 8, VF = 1, VS = 2, VB = 1;
    localparam int LL = 4;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int S_SEARCH = 0, S_HACQ = 1, S_VACQ = 2, S_VCHK = 3, S_LOCK = 4;

    logic clk = 1'b0, rst = 1'b1, hsync = 1'b1, vsync = 1'b1;
    logic [9:0] x, y;
    logic active, line_start, frame_start, locked, h_err, v_err;

    vga_sync_decoder #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(0), .LOCK_LINES(LL)
    ) dut (
        .px_clk_i(clk), .reset_i(rst), .hsync_i(hsync), .vsync_i(vsync),
        .x_o(x), .y_o(y), .active_o(active), .line_start_o(line_start),
        .frame_start_o(frame_start), .locked_o(locked), .h_err_o(h_err), .v_err_o(v_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {6'd0, x, y, active, line_start, frame_start, locked, h_err, v_err};
    endfunction

    // Generator: line length, sync width and frame height can be perturbed for one line/frame.
    int g_h, g_v, line_len = HT, sync_w = HS, frame_lines = VT, mute = 0;
    int ghist_h[4], ghist_v[4];

    task automatic gen_step();
        if (g_h >= line_len - 1) begin
            g_h = 0;
            line_len = HT;
            sync_w = HS;
            if (g_v >= frame_lines - 1) begin
                g_v = 0;
                frame_lines = VT;
            end else g_v++;
        end else g_h++;
        hsync = !(g_h >= HA + HF && g_h < HA + HF + sync_w);
        if (mute > 0) begin
            hsync = 1'b1;
            mute--;
        end
        vsync = !(g_v >= VA + VF && g_v < VA + VF + VS);
        for (int i = 3; i > 0; i--) begin
            ghist_h[i] = ghist_h[i-1];
            ghist_v[i] = ghist_v[i-1];
        end
        ghist_h[0] = g_h;
        ghist_v[0] = g_v;
    endtask

    // Reference: pins seen through a 2-deep sync plus one edge stage; widths and loss of
    // signal measured as edge-time differences; raster position kept modulo the totals.
    bit m_hs1, m_hs2, m_hs3, m_vs1, m_vs2, m_vs3, m_locked, m_wok;
    int m_h, m_v, m_vl, m_state, m_gl, t = 0, t_rise = 0;
    logic [31:0] m_exp = 0;

    task automatic model_step();
        bit r, f, vr, vf, wrap, herr, verr, los, act, ls, fs;
        int vnext;
        if (rst) begin
            {m_hs1, m_hs2, m_hs3, m_vs1, m_vs2, m_vs3} = '0;
            m_h = 0; m_v = 0; m_vl = 0; m_gl = 0;
            m_state = S_SEARCH; m_locked = 0; m_wok = 0;
            t_rise = t;
            m_exp = 0;
        end else begin
            r  = m_hs2 && !m_hs3;
            f  = !m_hs2 && m_hs3;
            vr = m_vs2 && !m_vs3;
            vf = !m_vs2 && m_vs3;
            wrap = !r && (m_h == HT - 1);
            herr = (r && m_h != HA + HF - 1) || (f && (t - t_rise) != HS);
            vnext = wrap ? (m_v + 1) % VT : m_v;
            if (vr) m_vl = 0;
            else if (wrap && m_vs3) m_vl++;
            verr = (m_state == S_VCHK || m_state == S_LOCK) &&
                   ((vr && vnext != VA + VF) || (vf && m_vl != VS));
            los = (m_state != S_SEARCH) && !r && ((t - t_rise) == 2 * HT);
            m_locked = (m_state == S_LOCK);
            if (los) m_state = S_SEARCH;
            else case (m_state)
                S_SEARCH: if (r) begin m_state = S_HACQ; m_gl = 0; end
                S_HACQ: begin
                    if (herr) m_gl = 0;
                    else if (r && m_wok) begin
                        m_gl++;
                        if (m_gl == LL) m_state = S_VACQ;
                    end
                end
                S_VACQ: if (herr) m_state = S_SEARCH; else if (vr) m_state = S_VCHK;
                S_VCHK: if (herr || verr) m_state = S_SEARCH; else if (vr) m_state = S_LOCK;
                default: if (herr || verr) m_state = S_SEARCH;
            endcase
            if (f) m_wok = ((t - t_rise) == HS);
            m_h = r ? HA + HF : (m_h + 1) % HT;
            m_v = vr ? VA + VF : vnext;
            if (r) t_rise = t;
            act = m_locked && m_h < HA && m_v < VA;
            ls  = m_locked && m_h == 0 && m_v < VA;
            fs  = m_locked && m_h == 0 && m_v == 0;
            m_exp = {6'd0, 10'(m_h), 10'(m_v), act, ls, fs, m_locked, herr, verr};
            m_hs3 = m_hs2; m_hs2 = m_hs1; m_hs1 = (hsync == 1'b0);
            m_vs3 = m_vs2; m_vs2 = m_vs1; m_vs1 = (vsync == 1'b0);
        end
        t++;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        gen_step();
        @(negedge clk);
        check("outs", outs(), m_exp);
    endtask

    task automatic wait_h(input int h);
        for (int i = 0; i < 2 * HT && g_h != h; i++) cycle();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        cycle();
        check("rst_zero", outs(), 32'd0);
        rst = 1'b0;
    endtask

    task automatic window_check();
        int na = 0, nl = 0, nf = 0, ne = 0;
        check("locked_pre", {31'd0, locked}, 32'd1);
        for (int i = 0; i < 2 * HT * VT; i++) begin
            cycle();
            na += int'(active);
            nl += int'(line_start);
            nf += int'(frame_start);
            ne += int'(h_err) + int'(v_err);
            check("xy_gen", {12'd0, x, y}, {12'd0, 10'(ghist_h[3]), 10'(ghist_v[3])});
        end
        check("active_cnt", na, 2 * HA * VA);
        check("line_cnt", nl, 2 * VA);
        check("frame_cnt", nf, 2);
        check("err_cnt", ne, 0);
    endtask

    task automatic inject(input int kind);
        case (kind)
            0: begin wait_h(5); line_len = HT - 1; end
            1: begin wait_h(5); sync_w = HS + 1; end
            2: begin
                for (int i = 0; i < 2 * HT * VT && !(g_v == 2 && g_h == 0); i++) cycle();
                frame_lines = VT - 1;
            end
            3: begin wait_h(HA + HF + HS + 1); mute = 2 * HT; end
            default: begin
                repeat ($urandom_range(1, 30)) cycle();
                pulse_reset();
                for (int i = 0; i < 2000 && m_state != S_VCHK; i++) cycle();
                check("reach_vchk", m_state, S_VCHK);
                repeat ($urandom_range(1, 20)) cycle();
                pulse_reset();
            end
        endcase
    endtask

    initial begin
        g_h = $urandom_range(0, HT - 1);
        g_v = $urandom_range(0, VT - 1);
        rst = 1'b1;
        repeat (3) cycle();
        check("rst_zero", outs(), 32'd0);
        rst = 1'b0;
        repeat (1200) cycle();
        check("lock_first", {31'd0, locked}, 32'd1);
        window_check();
        for (int it = 0; it < 12; it++) begin
            inject((it < 5) ? it : int'($urandom_range(0, 4)));
            repeat (2000) cycle();
            check("relock", {31'd0, locked}, 32'd1);
            window_check();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
